// File: rtl/ram2p_be.sv
// ram2p_be: true dual-port byte-enable RAM with reset-driven clear, collision flag and optional parity (RAM2P_BE_PARITY_EN).
// Read latency 1 (2 with OUT_REG); no backpressure, accesses are taken only while ready is high.
module ram2p_be #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int OUT_REG = 0,
    parameter int RDW_MODE = 0,
    localparam int NB = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  ready,
    input  logic                  en0,
    input  logic [NB-1:0]         we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rvalid0,
    input  logic                  en1,
    input  logic [NB-1:0]         we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid1,
`ifdef RAM2P_BE_PARITY_EN
    input  logic                  perr_inj0,
    input  logic                  perr_inj1,
    output logic                  perr0,
    output logic                  perr1,
`endif
    output logic                  coll
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM2P_BE_PARITY_EN
    localparam int PW = NB;
`else
    localparam int PW = 0;
`endif
    localparam int W = DATA_WIDTH + PW;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ready_q;
    logic                  coll_q;
    logic [W-1:0]          mem [DEPTH];

    logic                  clr, acc0, acc1, coll_d;
    logic [1:0]            acc;
    logic [ADDR_WIDTH-1:0] wa0;
    logic [DATA_WIDTH-1:0] wd0;
    logic [NB-1:0]         wbe0, wbe1;
    logic [W-1:0]          rw0, rw1;
    logic [DATA_WIDTH-1:0] rd_d [2];
    logic [DATA_WIDTH-1:0] pipe_q [2];
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [1:0]            pipe_vld_q, rvalid_q;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [DATA_WIDTH-1:0] wd,
                                           input logic [NB-1:0] be);
        logic [W-1:0] m;
        m = old;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                m[b*BYTE_WIDTH +: BYTE_WIDTH] = wd[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM2P_BE_PARITY_EN
                m[DATA_WIDTH+b] = ^wd[b*BYTE_WIDTH +: BYTE_WIDTH];
`endif
            end
        end
        return m;
    endfunction

    // The clear sequencer borrows the port 0 write path; user traffic is gated until ready.
    assign clr    = rstn && (state_q == S_CLEAR);
    assign acc0   = rstn && ready_q && en0;
    assign acc1   = rstn && ready_q && en1;
    assign acc    = {acc1, acc0};
    assign wa0    = clr ? cnt_q : addr0;
    assign wd0    = clr ? INIT_VALUE : wdata0;
    assign wbe0   = clr ? {NB{1'b1}} : ({NB{acc0}} & we0);
    assign wbe1   = {NB{acc1}} & we1;
    assign coll_d = acc0 && acc1 && (addr0 == addr1) && ((we0 & we1) != '0);

`ifdef RAM2P_BE_PARITY_EN
    logic [NB-1:0] inj0_m, inj1_m;
    assign inj0_m = {NB{perr_inj0 && !clr}};
    assign inj1_m = {NB{perr_inj1}};
`endif

    // Port 1 is applied after port 0 so it owns overlapping lanes on a collision.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wbe0[b]) begin
                mem[wa0][b*BYTE_WIDTH +: BYTE_WIDTH] <= wd0[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM2P_BE_PARITY_EN
                mem[wa0][DATA_WIDTH+b] <= ^wd0[b*BYTE_WIDTH +: BYTE_WIDTH] ^ inj0_m[b];
`endif
            end
            if (wbe1[b]) begin
                mem[addr1][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata1[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM2P_BE_PARITY_EN
                mem[addr1][DATA_WIDTH+b] <= ^wdata1[b*BYTE_WIDTH +: BYTE_WIDTH] ^ inj1_m[b];
`endif
            end
        end
    end

    // Write-first merges only the port's own write; the other port's write is never visible here.
    always_comb begin
        rw0 = mem[addr0];
        rw1 = mem[addr1];
        if (RDW_MODE != 0) begin
            rw0 = merge(rw0, wdata0, we0);
            rw1 = merge(rw1, wdata1, we1);
`ifdef RAM2P_BE_PARITY_EN
            rw0[W-1:DATA_WIDTH] = rw0[W-1:DATA_WIDTH] ^ (we0 & {NB{perr_inj0}});
            rw1[W-1:DATA_WIDTH] = rw1[W-1:DATA_WIDTH] ^ (we1 & {NB{perr_inj1}});
`endif
        end
    end

    assign rd_d[0] = rw0[DATA_WIDTH-1:0];
    assign rd_d[1] = rw1[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pipe_vld_q <= '0;
            rvalid_q   <= '0;
            coll_q     <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                pipe_q[p]  <= '0;
                rdata_q[p] <= '0;
            end
        end else begin
            coll_q     <= coll_d;
            pipe_vld_q <= acc;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) pipe_q[p] <= rd_d[p];
            end
            if (OUT_REG != 0) begin
                rvalid_q <= pipe_vld_q;
                for (int p = 0; p < 2; p++) begin
                    if (pipe_vld_q[p]) rdata_q[p] <= pipe_q[p];
                end
            end else begin
                rvalid_q <= acc;
                for (int p = 0; p < 2; p++) begin
                    if (acc[p]) rdata_q[p] <= rd_d[p];
                end
            end
        end
    end

`ifdef RAM2P_BE_PARITY_EN
    function automatic logic [NB-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b] = ^d[b*BYTE_WIDTH +: BYTE_WIDTH];
        return p;
    endfunction

    logic [1:0] err_d, perr_pipe_q, perr_q;
    assign err_d[0] = (rw0[W-1:DATA_WIDTH] != lane_par(rw0[DATA_WIDTH-1:0]));
    assign err_d[1] = (rw1[W-1:DATA_WIDTH] != lane_par(rw1[DATA_WIDTH-1:0]));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perr_pipe_q <= '0;
            perr_q      <= '0;
        end else begin
            perr_pipe_q <= acc & err_d;
            perr_q      <= (OUT_REG != 0) ? perr_pipe_q : (acc & err_d);
        end
    end

    assign perr0 = perr_q[0];
    assign perr1 = perr_q[1];
`endif

    assign ready   = ready_q;
    assign rdata0  = rdata_q[0];
    assign rdata1  = rdata_q[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign coll    = coll_q;
endmodule
